i2c_pwm_regfile_slave: RTL and testbench
========================================

Name: i2c_pwm_regfile_slave

Overview:
Parametrised I2C target (slave) that exposes NUM_CH 8-bit PWM duty registers behind a register pointer. It supports multi-byte writes with pointer auto-increment, reads back the registers, and handles repeated START. It NACKs foreign addresses and out-of-range pointers. It sits between the robot's I2C bus pins and the per-channel PWM generators, and is the multi-channel successor of the single-value PWM target.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit bus address.
NUM_CH, 4, number of PWM registers (1..16).
RST_DUTY, 8'h00, reset value of every PWM register.

Ports:
clk  in  1  system clock; must be >= 16x SCL frequency.
rst  in  1  reset, asynchronous, active-high.
scl  in  1  raw bus SCL.
sda_i  in  1  raw bus SDA (input buffer).
sda_drive_low  out  1  1 = pull SDA low (open-drain); 0 = release.
pwm_values  out  8*NUM_CH  flat duty registers; channel k occupies bits [8k+7:8k].
wr_strobe  out  NUM_CH  one-clk pulse on the bit of the channel just written.
busy  out  1  1 from detected START until STOP or return to IDLE.

Behaviour:
- Reset state: sda_drive_low=0, pwm_values=all RST_DUTY, wr_strobe=0, busy=0, pointer=0, state IDLE.
- Input conditioning: scl and sda_i each pass through a 2-flop synchroniser plus a third history flop. Edges and conditions are decoded from the last two synchronised samples.
  - scl_rise = 01; scl_fall = 10.
  - START = SDA 1->0 while SCL high; STOP = SDA 0->1 while SCL high.
  - Detection latency is 3 clk from the pin.
- SDA is sampled on scl_rise only. sda_drive_low changes only on scl_fall, or on STOP/START/IDLE, where it is released.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- START from any state (including repeated START mid-transfer) -> ADDR, bit counter=0, busy=1, SDA released. START has priority over the scl edge in the same clk.
- STOP in any state -> IDLE, busy=0, SDA released. The pointer is retained.
- ADDR: shift 8 bits MSB first.
  - Bits[7:1]==SLAVE_ADDR -> ADDR_ACK.
  - Otherwise -> WAIT_STOP with no ACK; the block ignores all traffic until the next START or STOP.
- ACK phase timing (all *_ACK states where the slave acks): on scl_fall drive low. On the next scl_rise the ACK is sampled by the master. On the following scl_fall release SDA and move on.
- ADDR_ACK exit: R/W=0 -> PTR; R/W=1 -> RDATA.
- PTR: shift 8 bits.
  - Value < NUM_CH: load pointer, ACK, -> WDATA.
  - Value >= NUM_CH: NACK (SDA stays released), pointer unchanged, -> WAIT_STOP.
- WDATA: shift 8 bits, then ACK.
  - On the ACK's scl_fall (drive-low edge): register[pointer] <= byte, wr_strobe[pointer]=1 for exactly one clk, pointer <= (pointer+1) mod NUM_CH.
  - Then -> WDATA.
- RDATA: the slave presents register[pointer] MSB first.
  - Bit 7 is driven after the ADDR_ACK release edge; each later bit changes on scl_fall.
  - A 0 bit drives low; a 1 bit releases.
  - After bit 0, SDA is released on scl_fall -> RDATA_ACK.
- RDATA_ACK: sample the master bit on scl_rise.
  - ACK (0): pointer <= (pointer+1) mod NUM_CH, -> RDATA.
  - NACK (1): -> WAIT_STOP.
- Pointer wrap: writes/reads past NUM_CH-1 wrap to 0. There is no error.
- Reset mid-transfer: immediate return to reset state; SDA is released asynchronously.

Optional Feature:
Macro I2C_GENERAL_CALL_EN.
- Defined: address byte 0x00 with W is ACKed as a general call. The first data byte after it (no pointer phase) is written to all NUM_CH registers simultaneously, with all wr_strobe bits pulsed. Further bytes are NACKed -> WAIT_STOP.
- Undefined: address 0x00 is treated as a foreign address and is NACKed.

Test Plan:
1. Reset with NUM_CH=4 -> pwm_values=32'h00000000, sda_drive_low=0, busy=0.
2. START, 0x84, ptr 0x01, data 0x3C, STOP -> all three bytes ACKed. Channel 1 = 0x3C, wr_strobe=4'b0010 for one clk, pointer=2.
3. Write ptr 0x03, data 0x11, 0x22 -> channel 3=0x11, channel 0=0x22 (wrap). Pointer=1.
4. Write ptr 0x02, repeated START, 0x85, read 2 bytes (ACK, NACK), STOP -> returns channel 2 then channel 3 values. SDA is released after the NACK.
5. Address 0x86, or ptr 0x07 -> no ACK (SDA high at the 9th clock), registers unchanged. The next valid transaction succeeds.
6. Assert rst mid-WDATA (bit 4) -> sda_drive_low=0 and all registers=RST_DUTY immediately. With I2C_GENERAL_CALL_EN: 0x00, 0x55 -> all channels=0x55.

Source files
------------

// File: rtl/i2c_pwm_regfile_slave.sv
`timescale 1ns/1ps
// Purpose    : I2C target exposing NUM_CH 8-bit PWM duty registers behind an auto-incrementing pointer.
// Latency    : bus conditions are seen 3 clk after the pin; SDA and register updates follow the decoded SCL edge by 1 clk.
// Backpressure: none; the target never stretches SCL, so clk must run at least 16x the SCL rate.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   scl, sda_i        raw bus lines (sampled through 2-flop synchronisers)
//   sda_drive_low     open-drain SDA pull-down request (1 = pull low)
//   pwm_values        flat duty registers, channel k at [8k+7:8k]
//   wr_strobe         one-clk pulse on each channel written
//   busy              high between a detected START and STOP
//
// Build option: define I2C_GENERAL_CALL_EN to accept general-call address 0x00 (write);
// the first data byte after it is written to every channel at once.
module i2c_pwm_regfile_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         NUM_CH     = 4,
    parameter logic [7:0] RST_DUTY   = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda_i,
    output logic                  sda_drive_low,
    output logic [8*NUM_CH-1:0]   pwm_values,
    output logic [NUM_CH-1:0]     wr_strobe,
    output logic                  busy
);

`ifdef I2C_GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP = 4'd9;

    localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);
    localparam logic [3:0] LAST_CH  = 4'(NUM_CH - 1);

    // [0],[1] synchronise, [2] holds the previous synchronised sample.
    // Reset to 1 so the idle bus does not look like an edge after reset.
    logic [2:0] r_scl_sync;
    logic [2:0] r_sda_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], scl};
            r_sda_sync <= {r_sda_sync[1:0], sda_i};
        end
    end

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = ~r_scl_sync[2] &  r_scl_sync[1];
    assign w_scl_fall =  r_scl_sync[2] & ~r_scl_sync[1];
    assign w_start    =  r_scl_sync[2] &  r_scl_sync[1] &  r_sda_sync[2] & ~r_sda_sync[1];
    assign w_stop     =  r_scl_sync[2] &  r_scl_sync[1] & ~r_sda_sync[2] &  r_sda_sync[1];

    logic [3:0]            r_state;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;     // incoming byte
    logic [7:0]            r_tx;        // remaining read bits, next one in [7]
    logic [3:0]            r_ptr;
    logic                  r_rw;
    logic                  r_ack_drv;   // ACK states: second half of the ack slot pending
    logic                  r_gc;        // current transfer is a general call
    logic                  r_gc_done;   // general-call byte already taken
    logic                  r_sda_low;
    logic                  r_busy;
    logic [NUM_CH-1:0]     r_strobe;
    logic [8*NUM_CH-1:0]   r_pwm;

    logic [7:0] w_byte;
    logic [3:0] w_ptr_nxt;
    logic [7:0] w_rd_byte;

    // Byte as it stands once the bit on the current SCL rise is shifted in.
    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_ptr_nxt = (r_ptr == LAST_CH) ? 4'd0 : r_ptr + 4'd1;

    always_comb begin
        w_rd_byte = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_ptr == 4'(k)) begin
                w_rd_byte = r_pwm[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 8'h00;
            r_ptr     <= 4'd0;
            r_rw      <= 1'b0;
            r_ack_drv <= 1'b0;
            r_gc      <= 1'b0;
            r_gc_done <= 1'b0;
            r_sda_low <= 1'b0;
            r_busy    <= 1'b0;
            r_strobe  <= '0;
            r_pwm     <= {NUM_CH{RST_DUTY}};
        end else begin
            r_strobe <= '0;
            if (w_start) begin
                // START wins over any SCL edge decoded in the same cycle.
                r_state   <= ST_ADDR;
                r_bit_cnt <= 3'd0;
                r_busy    <= 1'b1;
                r_sda_low <= 1'b0;
                r_ack_drv <= 1'b0;
                r_gc      <= 1'b0;
                r_gc_done <= 1'b0;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_sda_low <= 1'b0;
                r_ack_drv <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_low <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
                                if (w_byte[7:1] == SLAVE_ADDR) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= ST_ADDR_ACK;
                                end else if (GC_EN && (w_byte == 8'h00)) begin
                                    r_rw    <= 1'b0;
                                    r_gc    <= 1'b1;
                                    r_state <= ST_ADDR_ACK;
                                end else begin
                                    r_state <= ST_WAIT_STOP;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                r_sda_low <= 1'b1;
                                r_ack_drv <= 1'b1;
                            end else begin
                                r_ack_drv <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                if (r_rw) begin
                                    // Bit 7 goes out on the same edge that ends the ack slot.
                                    r_sda_low <= ~w_rd_byte[7];
                                    r_tx      <= {w_rd_byte[6:0], 1'b0};
                                    r_state   <= ST_RDATA;
                                end else begin
                                    r_sda_low <= 1'b0;
                                    r_state   <= r_gc ? ST_WDATA : ST_PTR;
                                end
                            end
                        end
                    end

                    ST_PTR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
                                if (w_byte < NUM_CH_B) begin
                                    r_ptr   <= w_byte[3:0];
                                    r_state <= ST_PTR_ACK;
                                end else begin
                                    r_state <= ST_WAIT_STOP;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end

                    ST_PTR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                r_sda_low <= 1'b1;
                                r_ack_drv <= 1'b1;
                            end else begin
                                r_sda_low <= 1'b0;
                                r_ack_drv <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= ST_WDATA;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
                                // A general call takes exactly one byte; the rest are refused.
                                r_state   <= (r_gc && r_gc_done) ? ST_WAIT_STOP : ST_WDATA_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end

                    ST_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                r_sda_low <= 1'b1;
                                r_ack_drv <= 1'b1;
                                for (int k = 0; k < NUM_CH; k++) begin
                                    if (r_gc || (r_ptr == 4'(k))) begin
                                        r_pwm[8*k +: 8] <= r_shift;
                                        r_strobe[k]     <= 1'b1;
                                    end
                                end
                                if (r_gc) begin
                                    r_gc_done <= 1'b1;
                                end else begin
                                    r_ptr <= w_ptr_nxt;
                                end
                            end else begin
                                r_sda_low <= 1'b0;
                                r_ack_drv <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= ST_WDATA;
                            end
                        end
                    end

                    ST_RDATA: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_sda_low <= 1'b0;
                                r_ack_drv <= 1'b0;
                                r_state   <= ST_RDATA_ACK;
                            end else begin
                                r_sda_low <= ~r_tx[7];
                                r_tx      <= {r_tx[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end

                    ST_RDATA_ACK: begin
                        // r_ack_drv here marks "master acked, next byte starts on the coming fall".
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_ptr     <= w_ptr_nxt;
                                r_ack_drv <= 1'b1;
                            end else begin
                                r_state <= ST_WAIT_STOP;
                            end
                        end else if (w_scl_fall && r_ack_drv) begin
                            r_ack_drv <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            r_sda_low <= ~w_rd_byte[7];
                            r_tx      <= {w_rd_byte[6:0], 1'b0};
                            r_state   <= ST_RDATA;
                        end
                    end

                    ST_WAIT_STOP: begin
                        r_sda_low <= 1'b0;
                    end

                    default: begin
                        r_state   <= ST_IDLE;
                        r_sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_drive_low = r_sda_low;
    assign pwm_values    = r_pwm;
    assign wr_strobe     = r_strobe;
    assign busy          = r_busy;

endmodule

// File: tb/tb_i2c_pwm_regfile_slave.sv
`timescale 1ns/1ps
module tb_i2c_pwm_regfile_slave;

    localparam logic [6:0] SLAVE_ADDR = 7'h42;
    localparam int         NUM_CH     = 4;
    localparam logic [7:0] RST_DUTY   = 8'h00;
    localparam int         Q          = 60;   // quarter SCL period in ns (6 clk)

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  scl;
    logic                  m_sda;             // master side, 1 = released
    logic                  sda_bus;
    logic                  sda_drive_low;
    logic [8*NUM_CH-1:0]   pwm_values;
    logic [NUM_CH-1:0]     wr_strobe;
    logic                  busy;

    always #5 clk = ~clk;

    // Wired-AND open-drain bus.
    assign sda_bus = m_sda & ~sda_drive_low;

    i2c_pwm_regfile_slave #(
        .SLAVE_ADDR (SLAVE_ADDR),
        .NUM_CH     (NUM_CH),
        .RST_DUTY   (RST_DUTY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .scl           (scl),
        .sda_i         (sda_bus),
        .sda_drive_low (sda_drive_low),
        .pwm_values    (pwm_values),
        .wr_strobe     (wr_strobe),
        .busy          (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    int                strobe_cycles = 0;
    logic [NUM_CH-1:0] last_strobe   = '0;
    always @(negedge clk) begin
        if (wr_strobe != '0) begin
            strobe_cycles = strobe_cycles + 1;
            last_strobe   = wr_strobe;
        end
    end

    // Transaction-level reference model.
    logic [7:0] m_reg [NUM_CH];
    int         m_ptr;

    function automatic logic [8*NUM_CH-1:0] model_flat();
        logic [8*NUM_CH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[8*k +: 8] = m_reg[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_reg[k] = RST_DUTY;
        m_ptr = 0;
    endtask

    // ---------------- bus master ----------------
    task automatic clock_bit(input logic b, output logic r);
        m_sda = b;
        #Q; scl = 1'b1;
        #Q; r = sda_bus;
        #Q; scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        #Q; scl = 1'b1;
        #Q; m_sda = 1'b0;
        #Q; scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        #Q; scl = 1'b1;
        #Q; m_sda = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
        end
        clock_bit(nack, r);
    endtask

    task automatic bus_recover();
        #9;
        scl   = 1'b1;
        m_sda = 1'b1;
        #50;
        rst = 1'b0;
        #100;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
        #50;
        model_reset();
        n_cmp++; if (pwm_values !== {NUM_CH{RST_DUTY}}) begin n_err++; $display("FAIL reset_pwm: got %h want %h", pwm_values, {NUM_CH{RST_DUTY}}); end
        n_cmp++; if (sda_drive_low !== 1'b0) begin n_err++; $display("FAIL reset_sda: got %b want 0", sda_drive_low); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (wr_strobe !== '0) begin n_err++; $display("FAIL reset_strobe: got %b want 0", wr_strobe); end
        rst = 1'b0;
        #100;
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        int   s0;
        s0 = strobe_cycles;
        i2c_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start: got %b want 1", busy); end
        write_byte(8'h84, a0);
        write_byte(8'h01, a1);
        write_byte(8'h3C, a2);
        i2c_stop();
        m_reg[1] = 8'h3C; m_ptr = 2;
        n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL single_acks: got %b want 000", {a0, a1, a2}); end
        n_cmp++; if (pwm_values !== model_flat()) begin n_err++; $display("FAIL single_pwm: got %h want %h", pwm_values, model_flat()); end
        n_cmp++; if (strobe_cycles - s0 !== 1) begin n_err++; $display("FAIL single_strobe_cycles: got %0d want 1", strobe_cycles - s0); end
        n_cmp++; if (last_strobe !== 4'b0010) begin n_err++; $display("FAIL single_strobe_mask: got %b want 0010", last_strobe); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3, a4;
        logic [7:0] d;
        int   s0;
        s0 = strobe_cycles;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h03, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop();
        m_reg[3] = 8'h11; m_reg[0] = 8'h22; m_ptr = 1;
        n_cmp++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_err++; $display("FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3}); end
        n_cmp++; if (pwm_values !== model_flat()) begin n_err++; $display("FAIL wrap_pwm: got %h want %h", pwm_values, model_flat()); end
        n_cmp++; if (strobe_cycles - s0 !== 2) begin n_err++; $display("FAIL wrap_strobe_cycles: got %0d want 2", strobe_cycles - s0); end
        n_cmp++; if (last_strobe !== 4'b0001) begin n_err++; $display("FAIL wrap_strobe_mask: got %b want 0001", last_strobe); end
        // Pointerless read reveals where the pointer ended up.
        i2c_start();
        write_byte(8'h85, a4);
        read_byte(1'b1, d);
        i2c_stop();
        n_cmp++; if (a4 !== 1'b0) begin n_err++; $display("FAIL wrap_read_ack: got %b want 0", a4); end
        n_cmp++; if (d !== m_reg[m_ptr]) begin n_err++; $display("FAIL wrap_ptr_read: got %h want %h", d, m_reg[m_ptr]); end
    endtask

    task automatic test_repeated_start_read();
        logic a0, a1, a2, a3, a4, a5, a6;
        logic [7:0] v2, v3, d0, d1;
        v2 = 8'($urandom); v3 = 8'($urandom);
        i2c_start();
        write_byte(8'h84, a0); write_byte(8'h02, a1);
        write_byte(v2, a2);    write_byte(v3, a3);
        i2c_stop();
        m_reg[2] = v2; m_reg[3] = v3; m_ptr = 0;
        i2c_start();
        write_byte(8'h84, a4);
        write_byte(8'h02, a5);
        i2c_start();
        write_byte(8'h85, a6);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        n_cmp++; if (sda_drive_low !== 1'b0) begin n_err++; $display("FAIL rs_release_after_nack: got %b want 0", sda_drive_low); end
        i2c_stop();
        m_ptr = 3;
        n_cmp++; if ({a0, a1, a2, a3, a4, a5, a6} !== 7'b0) begin n_err++; $display("FAIL rs_acks: got %b want 0000000", {a0, a1, a2, a3, a4, a5, a6}); end
        n_cmp++; if (d0 !== v2) begin n_err++; $display("FAIL rs_read_ch2: got %h want %h", d0, v2); end
        n_cmp++; if (d1 !== v3) begin n_err++; $display("FAIL rs_read_ch3: got %h want %h", d1, v3); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rs_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_nack();
        logic a0, a1, a2, b0, b1, b2, c0, c1, c2, c3;
        logic [7:0] d, v;
        int s0;
        s0 = strobe_cycles;
        i2c_start();
        write_byte(8'h86, a0); write_byte(8'h00, a1); write_byte(8'hFF, a2);
        i2c_stop();
        n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL foreign_nacks: got %b want 111", {a0, a1, a2}); end
        i2c_start();
        write_byte(8'h84, b0); write_byte(8'h07, b1); write_byte(8'hA5, b2);
        i2c_stop();
        n_cmp++; if ({b0, b1, b2} !== 3'b011) begin n_err++; $display("FAIL badptr_acks: got %b want 011", {b0, b1, b2}); end
        n_cmp++; if (pwm_values !== model_flat()) begin n_err++; $display("FAIL nack_pwm_kept: got %h want %h", pwm_values, model_flat()); end
        n_cmp++; if (strobe_cycles - s0 !== 0) begin n_err++; $display("FAIL nack_no_strobe: got %0d want 0", strobe_cycles - s0); end
        // Pointer must be untouched by the refused pointer byte.
        i2c_start();
        write_byte(8'h85, c0);
        read_byte(1'b1, d);
        i2c_stop();
        n_cmp++; if (d !== m_reg[m_ptr]) begin n_err++; $display("FAIL badptr_ptr_kept: got %h want %h", d, m_reg[m_ptr]); end
        v = 8'($urandom);
        i2c_start();
        write_byte(8'h84, c1); write_byte(8'h00, c2); write_byte(v, c3);
        i2c_stop();
        m_reg[0] = v; m_ptr = 1;
        n_cmp++; if ({c0, c1, c2, c3} !== 4'b0000) begin n_err++; $display("FAIL recover_acks: got %b want 0000", {c0, c1, c2, c3}); end
        n_cmp++; if (pwm_values !== model_flat()) begin n_err++; $display("FAIL recover_pwm: got %h want %h", pwm_values, model_flat()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int         kind, p, n, s0;
            logic       a;
            logic [7:0] d;
            logic [6:0] fa;
            kind = $urandom_range(0, 3);
            s0   = strobe_cycles;
            if (kind <= 1) begin
                p = $urandom_range(0, NUM_CH + 3);
                n = $urandom_range(1, 3);
                i2c_start();
                write_byte(8'h84, a);
                n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL rnd_w_addr_ack it%0d: got %b want 0", it, a); end
                write_byte(8'(p), a);
                n_cmp++; if (a !== (p >= NUM_CH)) begin n_err++; $display("FAIL rnd_ptr_ack it%0d ptr %0d: got %b want %b", it, p, a, p >= NUM_CH); end
                if (p < NUM_CH) begin
                    m_ptr = p;
                    for (int j = 0; j < n; j++) begin
                        d = 8'($urandom);
                        write_byte(d, a);
                        n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL rnd_data_ack it%0d: got %b want 0", it, a); end
                        m_reg[m_ptr] = d;
                        m_ptr = (m_ptr + 1) % NUM_CH;
                    end
                end
                i2c_stop();
                n_cmp++; if (pwm_values !== model_flat()) begin n_err++; $display("FAIL rnd_pwm it%0d: got %h want %h", it, pwm_values, model_flat()); end
                n_cmp++; if (strobe_cycles - s0 !== ((p < NUM_CH) ? n : 0)) begin n_err++; $display("FAIL rnd_strobes it%0d: got %0d want %0d", it, strobe_cycles - s0, (p < NUM_CH) ? n : 0); end
            end else if (kind == 2) begin
                n = $urandom_range(1, 3);
                i2c_start();
                write_byte(8'h85, a);
                n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL rnd_r_addr_ack it%0d: got %b want 0", it, a); end
                for (int j = 0; j < n; j++) begin
                    read_byte(j == n - 1, d);
                    n_cmp++; if (d !== m_reg[m_ptr]) begin n_err++; $display("FAIL rnd_read it%0d byte%0d: got %h want %h", it, j, d, m_reg[m_ptr]); end
                    if (j < n - 1) m_ptr = (m_ptr + 1) % NUM_CH;
                end
                i2c_stop();
            end else begin
                do fa = 7'($urandom); while (fa == SLAVE_ADDR || fa == 7'h00);
                i2c_start();
                write_byte({fa, 1'($urandom)}, a);
                n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL rnd_foreign it%0d addr %h: got %b want 1", it, fa, a); end
                i2c_stop();
                n_cmp++; if (pwm_values !== model_flat()) begin n_err++; $display("FAIL rnd_foreign_pwm it%0d: got %h want %h", it, pwm_values, model_flat()); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic a, r;
        // Reset during bit 4 of a data byte.
        i2c_start();
        write_byte(8'h84, a); write_byte(8'h01, a);
        clock_bit(1'b1, r); clock_bit(1'b0, r); clock_bit(1'b1, r);
        m_sda = 1'b0;
        #Q; scl = 1'b1;
        #Q;
        rst = 1'b1;
        #1;
        n_cmp++; if (sda_drive_low !== 1'b0) begin n_err++; $display("FAIL rstmid_sda: got %b want 0", sda_drive_low); end
        n_cmp++; if (pwm_values !== {NUM_CH{RST_DUTY}}) begin n_err++; $display("FAIL rstmid_pwm: got %h want %h", pwm_values, {NUM_CH{RST_DUTY}}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        bus_recover();
        // Reset while the slave is pulling SDA low for an ACK.
        i2c_start();
        write_byte(8'h84, a);
        for (int i = 0; i < 8; i++) clock_bit(1'b0, r);
        m_sda = 1'b1;
        #Q; scl = 1'b1;
        #Q;
        n_cmp++; if (sda_drive_low !== 1'b1) begin n_err++; $display("FAIL rstack_pre_drive: got %b want 1", sda_drive_low); end
        rst = 1'b1;
        #1;
        n_cmp++; if (sda_drive_low !== 1'b0) begin n_err++; $display("FAIL rstack_release: got %b want 0", sda_drive_low); end
        bus_recover();
    endtask

    task automatic test_general_call();
        logic a0, a1, a2;
        int s0;
        s0 = strobe_cycles;
        i2c_start();
`ifdef I2C_GENERAL_CALL_EN
        write_byte(8'h00, a0); write_byte(8'h55, a1); write_byte(8'h66, a2);
        i2c_stop();
        for (int k = 0; k < NUM_CH; k++) m_reg[k] = 8'h55;
        n_cmp++; if ({a0, a1, a2} !== 3'b001) begin n_err++; $display("FAIL gc_acks: got %b want 001", {a0, a1, a2}); end
        n_cmp++; if (last_strobe !== {NUM_CH{1'b1}}) begin n_err++; $display("FAIL gc_strobe_mask: got %b want all ones", last_strobe); end
        n_cmp++; if (strobe_cycles - s0 !== 1) begin n_err++; $display("FAIL gc_strobe_cycles: got %0d want 1", strobe_cycles - s0); end
`else
        write_byte(8'h00, a0); write_byte(8'h55, a1); write_byte(8'h66, a2);
        i2c_stop();
        n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL gc_disabled_nacks: got %b want 111", {a0, a1, a2}); end
        n_cmp++; if (strobe_cycles - s0 !== 0) begin n_err++; $display("FAIL gc_disabled_strobe: got %0d want 0", strobe_cycles - s0); end
`endif
        n_cmp++; if (pwm_values !== model_flat()) begin n_err++; $display("FAIL gc_pwm: got %h want %h", pwm_values, model_flat()); end
    endtask

    initial begin
        rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
        #2;
        test_reset();
        test_single_write();
        test_wrap();
        test_repeated_start_read();
        test_nack();
        test_random();
        test_reset_mid();
        test_general_call();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
